// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory bridge.
// Contents:
//   - BUS_W         : data/address width of the processor port and the bus
//   - ERR_DATA_DEF  : default read data returned on aborted/illegal loads
//   - state_e       : bridge state machine encoding (IDLE, REQ, DONE)
//   - CNT_W         : width of the bus timeout counter
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int unsigned BUS_W = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [BUS_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Word-align a byte address for the bus.
  function automatic logic [BUS_W-1:0] word_align(input logic [BUS_W-1:0] addr);
    return {addr[BUS_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// dmem_timeout_ctr
// 8-bit bus-wait counter. It is held at zero while clr_i is high and counts
// up while en_i is high. expired_o flags that the current cycle is the last
// one allowed without an acknowledge (count == TIMEOUT-1).
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   clr_i     in   synchronous clear (wins over enable)
//   en_i      in   count enable
//   expired_o out  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module dmem_timeout_ctr
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge
// Turns the processor's single-cycle data-memory access into a req/ack
// transaction on a slower bus, stalling the processor until it completes.
// Misaligned and simultaneous read+write accesses are rejected without a bus
// cycle; bus accesses that see no ack within TIMEOUT cycles are aborted.
// Both cases raise a sticky err_flag and return ERR_DATA on loads.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_addr/cpu_wdata          processor byte address and store data
//   cpu_read/cpu_write          processor load/store requests
//   cpu_rdata                   registered load data (held until next load)
//   cpu_stall                   combinational freeze request (pc_enable = ~stall)
//   bus_req/bus_we/bus_addr/
//   bus_wdata                   registered bus request outputs
//   bus_ack/bus_rdata           bus completion strobe and read data
//   err_clr/err_flag            sticky error clear and indicator
// -----------------------------------------------------------------------------
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned      TIMEOUT  = 16,
  parameter logic [BUS_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] cpu_addr,
  input  logic [BUS_W-1:0] cpu_wdata,
  input  logic             cpu_read,
  input  logic             cpu_write,
  output logic [BUS_W-1:0] cpu_rdata,
  output logic             cpu_stall,
  output logic             bus_req,
  output logic             bus_we,
  output logic [BUS_W-1:0] bus_addr,
  output logic [BUS_W-1:0] bus_wdata,
  input  logic             bus_ack,
  input  logic [BUS_W-1:0] bus_rdata,
  input  logic             err_clr,
  output logic             err_flag
);

  state_e state_q;
  state_e state_d;

  logic             bus_req_q,   bus_req_d;
  logic             bus_we_q,    bus_we_d;
  logic [BUS_W-1:0] bus_addr_q,  bus_addr_d;
  logic [BUS_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [BUS_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic             err_flag_q,  err_flag_d;

  logic cpu_access;
  logic illegal;
  logic expired;
  logic ctr_clr;
  logic ctr_en;

  assign cpu_access = cpu_read | cpu_write;
  assign illegal    = (cpu_addr[1:0] != 2'b00) | (cpu_read & cpu_write);

  // The counter only runs inside REQ; any other state re-arms it at zero.
  assign ctr_clr = (state_q != ST_REQ);
  assign ctr_en  = (state_q == ST_REQ) & ~bus_ack;

  dmem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (ctr_clr),
    .en_i      (ctr_en),
    .expired_o (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_access) begin
          state_d = illegal ? ST_DONE : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // An ack in the last allowed cycle still completes normally.
        if (bus_ack || expired) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_REQ;
        end
      end
      // DONE ignores the CPU inputs: they still describe the finished access.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    logic err_set;
    err_set     = 1'b0;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_access) begin
          bus_addr_d  = word_align(cpu_addr);
          bus_wdata_d = cpu_wdata;
          bus_we_d    = cpu_write;
          if (illegal) begin
            err_set = 1'b1;
            if (cpu_read) begin
              cpu_rdata_d = ERR_DATA;
            end else begin
              cpu_rdata_d = cpu_rdata_q;
            end
          end else begin
            bus_req_d = 1'b1;
          end
        end else begin
          bus_req_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            cpu_rdata_d = bus_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else if (expired) begin
          bus_req_d = 1'b0;
          err_set   = 1'b1;
          if (!bus_we_q) begin
            cpu_rdata_d = ERR_DATA;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end else begin
          bus_req_d = 1'b1;
        end
      end
      ST_DONE: begin
        bus_req_d = 1'b0;
      end
      default: begin
        bus_req_d = 1'b0;
      end
    endcase
    // A new error in the same cycle as a clear must not be lost.
    if (err_set) begin
      err_flag_d = 1'b1;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
    end else begin
      err_flag_d = err_flag_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      cpu_rdata_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      err_flag_q  <= err_flag_d;
    end
  end

  // Stall is combinational so the processor freezes in the request cycle;
  // it is forced low while reset is asserted.
  always_comb begin
    cpu_stall = 1'b0;
    if (!rst_n) begin
      cpu_stall = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: cpu_stall = cpu_access;
        ST_REQ:  cpu_stall = 1'b1;
        ST_DONE: cpu_stall = 1'b0;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign err_flag  = err_flag_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bridge
// Self-checking bench for dmem_bridge. Each access is predicted from the
// bridge's rules (stall length, number of bus cycles, returned data, error
// flag) and compared against what the DUT does, cycle by cycle at negedge.
// -----------------------------------------------------------------------------
module tb_dmem_bridge;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam logic [31:0] ERR_WORD   = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err_clr;
  logic        err_flag;

  int total;
  int bad;

  // Reference state: last load data and the sticky error flag.
  logic [31:0] m_rdata;
  logic        m_err;

  dmem_bridge #(
    .TIMEOUT  (TB_TIMEOUT),
    .ERR_DATA (ERR_WORD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .err_clr   (err_clr),
    .err_flag  (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One CPU access. Called either at the negedge of a DONE cycle (back-to-back)
  // or mid-way through an IDLE cycle; the next negedge is the first stall cycle.
  // ack_dly = number of REQ cycles before the ack (>= TB_TIMEOUT means none).
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input int ack_dly,
                            input logic [31:0] brd, input logic clr, input string name);
    bit          illegal;
    int          exp_stall;
    int          exp_reqs;
    int          stalls;
    int          reqs;
    int          first_req;
    int          cyc;
    bit          done;
    logic [31:0] exp_addr;
    illegal  = (addr[1:0] != 2'b00) || (rd && wr);
    exp_addr = addr & 32'hFFFF_FFFC;
    if (clr) m_err = 1'b0;
    if (illegal) begin
      exp_stall = 1;
      exp_reqs  = 0;
      if (rd) m_rdata = ERR_WORD;
      m_err = 1'b1;
    end else if (ack_dly < int'(TB_TIMEOUT)) begin
      exp_stall = ack_dly + 2;
      exp_reqs  = ack_dly + 1;
      if (rd) m_rdata = brd;
    end else begin
      exp_stall = int'(TB_TIMEOUT) + 1;
      exp_reqs  = int'(TB_TIMEOUT);
      if (rd) m_rdata = ERR_WORD;
      m_err = 1'b1;
    end

    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    err_clr   = clr;
    stalls    = 0;
    reqs      = 0;
    first_req = -1;
    cyc       = 0;
    done      = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      bus_ack = 1'b0;
      if (cyc > 1) err_clr = 1'b0;
      if (cpu_stall) begin
        stalls++;
        if (bus_req) begin
          if (reqs == 0) first_req = cyc;
          total++;
          if (bus_addr !== exp_addr || bus_we !== wr || bus_wdata !== wd) begin
            bad++;
            $display("FAIL %s bus_fields: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                     name, bus_addr, bus_we, bus_wdata, exp_addr, wr, wd);
          end
          if (reqs == ack_dly) begin
            bus_ack   = 1'b1;
            bus_rdata = brd;
          end
          reqs++;
        end
      end else begin
        done = 1'b1;
      end
    end

    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s no_done: stall never dropped within %0d cycles", name, cyc);
    end
    total++;
    if (stalls !== exp_stall) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stall);
    end
    total++;
    if (reqs !== exp_reqs) begin
      bad++;
      $display("FAIL %s req_cycles: got %0d want %0d", name, reqs, exp_reqs);
    end
    if (!illegal) begin
      total++;
      if (first_req !== 2) begin
        bad++;
        $display("FAIL %s req_rise: got cycle %0d want 2", name, first_req);
      end
    end
    total++;
    if (bus_req !== 1'b0) begin
      bad++;
      $display("FAIL %s done_req: got %b want 0", name, bus_req);
    end
    total++;
    if (cpu_rdata !== m_rdata) begin
      bad++;
      $display("FAIL %s rdata: got %h want %h", name, cpu_rdata, m_rdata);
    end
    total++;
    if (err_flag !== m_err) begin
      bad++;
      $display("FAIL %s err_flag: got %b want %b", name, err_flag, m_err);
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic idle_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'h0000_0100;
    cpu_wdata = 32'h0;
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    err_clr   = 1'b0;
    m_rdata   = 32'h0;
    m_err     = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus_req !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 ||
        cpu_rdata !== 32'h0 || err_flag !== 1'b0 || cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: got req=%b we=%b addr=%h wdata=%h rdata=%h err=%b stall=%b want all zero",
               bus_req, bus_we, bus_addr, bus_wdata, cpu_rdata, err_flag, cpu_stall);
    end
    cpu_read = 1'b0;
    rst_n    = 1'b1;
    idle_step();
  endtask

  task automatic test_directed();
    run_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3, 32'h1234_5678, 1'b0, "load");
    idle_step();
    run_access(1'b0, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 0, 32'h0, 1'b0, "store");
    idle_step();
    run_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 255, 32'h0, 1'b0, "timeout");
  endtask

  task automatic test_err_clr();
    idle_step();
    err_clr = 1'b1;
    idle_step();
    err_clr = 1'b0;
    m_err   = 1'b0;
    total++;
    if (err_flag !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got %b want 0", err_flag);
    end
  endtask

  task automatic test_misaligned();
    idle_step();
    run_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h0, 1'b1, "misaligned");
    idle_step();
    run_access(1'b1, 1'b1, 32'h0000_0200, 32'h1111_2222, 0, 32'h0, 1'b0, "rd_and_wr");
  endtask

  task automatic test_back_to_back();
    test_err_clr();
    run_access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'hA5A5_0010, 1'b0, "b2b_load");
    run_access(1'b0, 1'b1, 32'h0000_0014, 32'h5A5A_0014, 2, 32'h0, 1'b0, "b2b_store");
  endtask

  task automatic test_stray_ack();
    idle_step();
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_0000;
    repeat (2) @(negedge clk);
    total++;
    if (bus_req !== 1'b0 || err_flag !== m_err || cpu_stall !== 1'b0 || cpu_rdata !== m_rdata) begin
      bad++;
      $display("FAIL stray_ack: got req=%b err=%b stall=%b rdata=%h want req=0 err=%b stall=0 rdata=%h",
               bus_req, err_flag, cpu_stall, cpu_rdata, m_err, m_rdata);
    end
    bus_ack = 1'b0;
    idle_step();
  endtask

  task automatic test_reset_mid_req();
    bit seen;
    run_access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 0, 32'h0, 1'b0, "pre_reset_err");
    idle_step();
    cpu_read = 1'b1;
    cpu_addr = 32'h0000_0020;
    seen     = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus_req) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL mid_reset_req: got no bus_req want bus_req before reset");
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_err   = 1'b0;
    m_rdata = 32'h0;
    total++;
    if (bus_req !== 1'b0 || cpu_stall !== 1'b0 || err_flag !== 1'b0 || cpu_rdata !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset: got req=%b stall=%b err=%b rdata=%h want 0 0 0 0",
               bus_req, cpu_stall, err_flag, cpu_rdata);
    end
    @(negedge clk);
    cpu_read = 1'b0;
    rst_n    = 1'b1;
    idle_step();
    run_access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1, 32'h0BAD_F00D, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      int          sel;
      sel  = int'($urandom_range(0, 9));
      rd   = (sel < 5) || (sel == 9);
      wr   = !rd || (sel == 9);
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 1) == 1) begin
        idle_step();
        bus_ack = $urandom_range(0, 1) == 1;
        idle_step();
        bus_ack = 1'b0;
      end
      run_access(rd, wr, addr, $urandom, int'($urandom_range(0, 5)), $urandom,
                 $urandom_range(0, 3) == 0, "random");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_err_clr();
    test_misaligned();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid_req();
    test_random();
    idle_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly downstream of the processor's data-memory port (data_addr, data_in, data_out, ctrl_mem_read, ctrl_mem_write).
- Converts the single-cycle combinational access into a multi-cycle req/ack transaction on a slower memory bus.
- Drives a stall that the top level inverts onto pc_enable, so the processor holds its state until the access completes.
- Adds a bus timeout, an alignment check and a sticky error flag.

Parameters:
- TIMEOUT, 16, bus cycles in REQ without ack before the access is aborted (valid range 1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on aborted, misaligned or illegal reads.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_addr  in  32  byte address from the processor ALU (data_addr).
- cpu_wdata  in  32  store data (data_in).
- cpu_read  in  1  load request (ctrl_mem_read).
- cpu_write  in  1  store request (ctrl_mem_write).
- cpu_rdata  out  32  load data to the processor (data_out).
- cpu_stall  out  1  freeze request; top level uses pc_enable = ~cpu_stall.
- bus_req  out  1  bus transaction valid.
- bus_we  out  1  1 = write, 0 = read.
- bus_addr  out  32  word-aligned bus address.
- bus_wdata  out  32  bus write data.
- bus_ack  in  1  bus completion strobe, one cycle.
- bus_rdata  in  32  bus read data, valid when bus_ack = 1.
- err_clr  in  1  clears err_flag.
- err_flag  out  1  sticky error indicator.

Behaviour:
- Clock and reset: one clock clk. rst_n is asynchronous, active-low.
- Reset values: state = IDLE; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; cpu_rdata = 0; err_flag = 0; timeout counter = 0.
- cpu_stall is combinational:
  - 1 in IDLE when (cpu_read | cpu_write) = 1.
  - 1 in REQ.
  - 0 in DONE.
  - It is 0 during reset.
- Bus outputs (bus_req, bus_we, bus_addr, bus_wdata) are registered. cpu_rdata is registered and holds its value until the next load completes.
- State machine:
  - IDLE: if cpu_read | cpu_write:
    - Latch cpu_addr, cpu_wdata and we = cpu_write.
    - If cpu_addr[1:0] != 0, or cpu_read & cpu_write: set err_flag, set cpu_rdata = ERR_DATA (for reads), and go to DONE without asserting bus_req. A simultaneous read and write is treated as illegal.
    - Otherwise assert bus_req, clear the counter, and go to REQ.
  - REQ: bus_req stays 1 and bus outputs stay stable.
    - On bus_ack: for reads, cpu_rdata <= bus_rdata; deassert bus_req; go to DONE.
    - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack: deassert bus_req, set err_flag, cpu_rdata <= ERR_DATA on reads, go to DONE.
  - DONE: lasts exactly one cycle with stall = 0, so the processor commits and advances its PC. CPU inputs are ignored in this cycle, because they still show the completed access. Next state is IDLE.
- Latency:
  - Ack in the first REQ cycle gives 2 stall cycles plus the DONE cycle.
  - Ack k cycles after bus_req rises gives k+2 stall cycles.
  - A misaligned or illegal access gives 1 stall cycle.
- Back-to-back accesses: IDLE re-evaluates fresh inputs in the cycle after DONE. No bus idle cycle is required beyond this.
- bus_ack outside REQ is ignored and is not an error.
- err_flag:
  - err_clr clears it.
  - If a set and err_clr occur in the same cycle, the set wins.
- Reset mid-transaction (rst_n low in REQ): bus_req drops immediately (asynchronous), the access is lost, and cpu_stall goes to 0.
- Width rules: bus_addr = {latched_addr[31:2], 2'b00}. The counter is 8 bits.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, REQ, DONE);
  - the default ERR_DATA constant;
  - the bus width constant 32.
- One natural sub-module, dmem_timeout_ctr: an 8-bit counter with clear, enable and an expired output compared against TIMEOUT.

Test Plan:
1. Aligned load: cpu_read = 1, cpu_addr = 0x100, bus_ack after 3 cycles with bus_rdata = 0x12345678.
   -> bus_addr = 0x100, bus_we = 0, stall high for 5 cycles, cpu_rdata = 0x12345678 in DONE.
2. Aligned store: cpu_write = 1, addr 0x204, wdata 0xCAFEF00D, immediate ack.
   -> bus_we = 1, bus_wdata = 0xCAFEF00D, stall for 2 cycles, err_flag = 0.
3. Timeout: TIMEOUT = 4, read at 0x40, bus_ack never asserted.
   -> bus_req drops after 4 REQ cycles, cpu_rdata = 0xDEADBEEF, err_flag = 1. A following err_clr pulse clears it.
4. Misaligned: read at 0x103.
   -> no bus_req, 1 stall cycle, cpu_rdata = 0xDEADBEEF, err_flag = 1.
   Same cycle err_clr = 1 -> err_flag still 1.
5. Back-to-back: load at 0x10, then store at 0x14 in the cycle after DONE.
   -> second bus_req rises the cycle after DONE, with the correct bus_addr and bus_we for each access.
6. Reset mid-REQ: assert rst_n = 0 while bus_req = 1.
   -> bus_req, cpu_stall and err_flag go to 0 immediately. After release, the state is IDLE and the next read at 0x8 completes normally.
